// File: rtl/div_clock_monitor.sv
// Receive-side checker for a divided clock synchronous to clk_in: measures the
// high/low phase lengths of each rise-to-rise period and reports lock, mismatch and stuck status.
module div_clock_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clk_div,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic             err_clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             err,
  output logic             err_sticky,
  output logic             locked,
  output logic             stuck
);

  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [3:0]        LOCK_MAX = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {ACQ, MEAS_HIGH, MEAS_LOW} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_d_q;
  logic [CNT_W-1:0]  r_hcnt;
  logic [CNT_W-1:0]  r_lcnt;
  logic [CNT_W-1:0]  r_hlat;
  logic [IDLE_W-1:0] r_idle;
  logic [3:0]        r_match_cnt;
  logic [3:0]        w_match_inc;
  logic              w_rise;
  logic              w_fall;
  logic              w_edge;
  logic              w_timeout;
  logic              w_publish;
  logic              w_match;

  assign w_rise      = clk_div & ~r_d_q;
  assign w_fall      = ~clk_div & r_d_q;
  assign w_edge      = w_rise | w_fall;
  // Fires once, on the edge where the idle count steps from TIMEOUT-1 to TIMEOUT.
  assign w_timeout   = ~w_edge && (r_idle == IDLE_MAX - IDLE_W'(1));
  assign w_publish   = (r_state == MEAS_LOW) && w_rise;
  assign w_match     = (r_hlat == exp_high) && (r_lcnt == exp_low);
  assign w_match_inc = (r_match_cnt == LOCK_MAX) ? LOCK_MAX : r_match_cnt + 4'd1;

  always_ff @(posedge clk_in) begin
    if (!reset_n) r_state <= ACQ;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through this block can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ACQ:       if (w_rise) w_state_nxt = MEAS_HIGH;
      MEAS_HIGH: if (w_fall) w_state_nxt = MEAS_LOW;
      MEAS_LOW:  if (w_rise) w_state_nxt = MEAS_HIGH;
      default:   w_state_nxt = ACQ;
    endcase
    if (w_timeout) w_state_nxt = ACQ;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_d_q       <= 1'b0;
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_hlat      <= '0;
      r_idle      <= '0;
      r_match_cnt <= '0;
      meas_valid  <= 1'b0;
      high_len    <= '0;
      low_len     <= '0;
      period      <= '0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      locked      <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      r_d_q      <= clk_div;
      meas_valid <= 1'b0;
      err        <= 1'b0;

      if (w_edge) begin
        r_idle <= '0;
        stuck  <= 1'b0;
      end else begin
        if (r_idle != IDLE_MAX) r_idle <= r_idle + IDLE_W'(1);
        if (w_timeout) begin
          stuck       <= 1'b1;
          locked      <= 1'b0;
          r_match_cnt <= '0;
        end
      end

      case (r_state)
        ACQ: if (w_rise) r_hcnt <= CNT_W'(1);
        MEAS_HIGH: begin
          if (w_fall) begin
            r_hlat <= r_hcnt;
            r_lcnt <= CNT_W'(1);
          end else if (clk_div && r_hcnt != CNT_MAX) begin
            r_hcnt <= r_hcnt + CNT_W'(1);
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            r_hcnt <= CNT_W'(1);
          end else if (!clk_div && r_lcnt != CNT_MAX) begin
            r_lcnt <= r_lcnt + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (w_publish) begin
        meas_valid <= 1'b1;
        high_len   <= r_hlat;
        low_len    <= r_lcnt;
        period     <= {1'b0, r_hlat} + {1'b0, r_lcnt};
        if (w_match) begin
          r_match_cnt <= w_match_inc;
          locked      <= (w_match_inc == LOCK_MAX);
        end else begin
          err         <= 1'b1;
          r_match_cnt <= '0;
          locked      <= 1'b0;
        end
      end

      // A mismatch in the same cycle as err_clr keeps the sticky flag set.
      if (w_publish && !w_match) err_sticky <= 1'b1;
      else if (err_clr)          err_sticky <= 1'b0;
    end
  end

endmodule
